// File: rtl/mips_pkg.sv
// Shared constants for the MIPS32 register dump engine: parameter defaults
// and FSM state encodings.
package mips_pkg;

  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned DW_DEF   = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

endpackage

// File: rtl/mips_edge_det.sv
// Rising-edge detector for the core HALTED flag. The history register resets
// to 0, so a core that is already halted at reset release yields one edge.
module mips_edge_det (
  input  logic clk1,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_c
);

  logic d_q;

  // Registered copy of the input for edge comparison
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign rise_c = d_i & ~d_q;

endmodule

// File: rtl/mips_reg_dump.sv
// Register-file read-out engine: on a halted rising edge or a start pulse it
// reads R0..R(NREG-1) through a one-cycle-latency port and streams each word
// with its index on a valid/ready interface.
// Optional build macro MIPS_DUMP_CSUM_EN: appends an XOR checksum beat
// (out_idx=0, out_csum=1) that carries out_last instead of R(NREG-1).
module mips_reg_dump
  import mips_pkg::*;
#(
  parameter  int unsigned NREG = NREG_DEF,
  parameter  int unsigned DW   = DW_DEF,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          start,
  output logic          rf_rd_en,
  output logic [AW-1:0] rf_rd_addr,
  input  logic [DW-1:0] rf_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last,
`ifdef MIPS_DUMP_CSUM_EN
  output logic          out_csum,
`endif
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  logic          halted_rise_c;
  logic          trig_c;
  logic [2:0]    state_q,     state_d;
  logic [AW-1:0] idx_q,       idx_d;
  logic          rf_rd_en_q,  rf_rd_en_d;
  logic [AW-1:0] rf_addr_q,   rf_addr_d;
  logic          valid_q,     valid_d;
  logic [AW-1:0] out_idx_q,   out_idx_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic          out_last_q,  out_last_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
`ifdef MIPS_DUMP_CSUM_EN
  logic [DW-1:0] csum_q,      csum_d;
  logic          csum_beat_q, csum_beat_d;
`endif

  mips_edge_det u_edge_det (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .d_i    (halted),
    .rise_c (halted_rise_c)
  );

  assign trig_c = halted_rise_c | start;

  // Next-state and next-output logic; all outputs are derived from state_d
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
`ifdef MIPS_DUMP_CSUM_EN
    csum_d      = csum_q;
    csum_beat_d = csum_beat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (trig_c) begin
          idx_d   = '0;
          state_d = ST_RD;
`ifdef MIPS_DUMP_CSUM_EN
          csum_d      = '0;
          csum_beat_d = 1'b0;
`endif
        end
      end
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        out_data_d = rf_rd_data;
        out_idx_d  = idx_q;
`ifdef MIPS_DUMP_CSUM_EN
        out_last_d = 1'b0;
        csum_d     = csum_q ^ rf_rd_data;
`else
        out_last_d = (idx_q == LAST_IDX);
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
`ifdef MIPS_DUMP_CSUM_EN
          if (csum_beat_q) begin
            csum_beat_d = 1'b0;
            state_d     = ST_FIN;
          end else if (idx_q == LAST_IDX) begin
            // Checksum beat follows the last register directly
            out_data_d  = csum_q;
            out_idx_d   = '0;
            out_last_d  = 1'b1;
            csum_beat_d = 1'b1;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_RD;
          end
`else
          if (out_last_q) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_RD;
          end
`endif
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rf_rd_en_d = (state_d == ST_RD);
    rf_addr_d  = (state_d == ST_RD) ? idx_d : rf_addr_q;
    valid_d    = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FIN);
  end

  // State and registered outputs
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rf_rd_en_q <= 1'b0;
      rf_addr_q  <= '0;
      valid_q    <= 1'b0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MIPS_DUMP_CSUM_EN
      csum_q      <= '0;
      csum_beat_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rf_rd_en_q <= rf_rd_en_d;
      rf_addr_q  <= rf_addr_d;
      valid_q    <= valid_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MIPS_DUMP_CSUM_EN
      csum_q      <= csum_d;
      csum_beat_q <= csum_beat_d;
`endif
    end
  end

  assign rf_rd_en   = rf_rd_en_q;
  assign rf_rd_addr = rf_addr_q;
  assign out_valid  = valid_q;
  assign out_idx    = out_idx_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef MIPS_DUMP_CSUM_EN
  assign out_csum   = csum_beat_q;
`endif

endmodule

// File: tb/tb_mips_reg_dump.sv
// Self-checking bench for mips_reg_dump: a bench-side register file answers
// reads, expected beats are queued when a dump is triggered and popped by a
// stream monitor on each accepted beat.
module tb_mips_reg_dump;

  localparam int NREG = 32;
`ifdef MIPS_DUMP_CSUM_EN
  localparam int NBEATS = NREG + 1;
`else
  localparam int NBEATS = NREG;
`endif

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        csum;
  } beat_t;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        halted = 1'b0;
  logic        start = 1'b0;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_csum_w;
  logic        busy;
  logic        done;

  logic [31:0] regs [NREG];
  beat_t       exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          beats = 0;

  mips_reg_dump dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .halted     (halted),
    .start      (start),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .out_last   (out_last),
`ifdef MIPS_DUMP_CSUM_EN
    .out_csum   (out_csum_w),
`endif
    .busy       (busy),
    .done       (done)
  );

`ifndef MIPS_DUMP_CSUM_EN
  assign out_csum_w = 1'b0;
`endif

  always #5 clk1 = ~clk1;

  // Register file model with one-cycle read latency
  always @(posedge clk1) if (rf_rd_en) rf_rd_data <= regs[rf_rd_addr];

  // Stream monitor: scoreboard pop on acceptance, hold check on stall
  logic  prev_stall = 1'b0;
  beat_t prev_b;
  always @(negedge clk1) begin
    beat_t cur, e;
    cur = '{idx: out_idx, data: out_data, last: out_last, csum: out_csum_w};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!out_valid || cur !== prev_b) begin
          bad++;
          $display("FAIL hold: valid=%0b beat=%h required valid=1 beat=%h", out_valid, cur, prev_b);
        end
      end
      if (out_valid && out_ready) begin
        beats++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got beat=%h required none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL beat: idx=%0d data=%h last=%0b csum=%0b required idx=%0d data=%h last=%0b csum=%0b",
                     cur.idx, cur.data, cur.last, cur.csum, e.idx, e.data, e.last, e.csum);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_b     = cur;
    end
  end

  task automatic push_dump();
    logic [31:0] x;
    x = 32'd0;
    for (int k = 0; k < NREG; k++) begin
      exp_q.push_back('{idx: 5'(k), data: regs[k], last: (k == NREG - 1) && (NBEATS == NREG), csum: 1'b0});
      x = x ^ regs[k];
    end
    if (NBEATS != NREG) exp_q.push_back('{idx: 5'd0, data: x, last: 1'b1, csum: 1'b1});
  endtask

  task automatic load_regs(input int mul);
    for (int k = 0; k < NREG; k++) regs[k] = 32'(k * mul);
  endtask

  // Waits for done at negedges; cyc = number of negedges waited, 0 on timeout
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk1);
      if (done) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk1); #1 start = 1'b1;
    @(posedge clk1); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    total++;
    if ({rf_rd_en, rf_rd_addr, out_valid, out_idx, out_data, out_last, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_vals: en=%0b addr=%0d valid=%0b idx=%0d data=%h last=%0b busy=%0b done=%0b required all 0",
               rf_rd_en, rf_rd_addr, out_valid, out_idx, out_data, out_last, busy, done);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk1);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: busy=%0b required 0", busy); end
  endtask

  task automatic test_halted_dump();
    int cyc;
    load_regs(1);
    beats = 0;
    push_dump();
    @(posedge clk1); #1 halted = 1'b1;
    @(posedge clk1);                      // trigger edge N
    wait_done(cyc);
    total++;
    if (cyc != 97 + (NBEATS - NREG)) begin
      bad++;
      $display("FAIL halted_done_latency: cyc=%0d required %0d", cyc, 97 + (NBEATS - NREG));
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_fin: busy=%0b required 1", busy); end
    @(negedge clk1);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL after_done: busy=%0b done=%0b required 0 0", busy, done);
    end
    total++;
    if (beats != NBEATS || exp_q.size() != 0) begin
      bad++;
      $display("FAIL halted_beats: beats=%0d left=%0d required %0d 0", beats, exp_q.size(), NBEATS);
    end
    halted = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit fin;
    fin = 1'b0;
    load_regs(3);
    beats = 0;
    push_dump();
    pulse_start();
    fork
      begin
        for (int c = 0; c < 3000 && !fin; c++) begin
          @(posedge clk1); #1 out_ready = ~out_ready;
        end
      end
      begin
        wait_done(cyc);
        fin = 1'b1;
      end
    join
    out_ready = 1'b1;
    total++;
    if (cyc == 0 || beats != NBEATS || exp_q.size() != 0) begin
      bad++;
      $display("FAIL backpressure: cyc=%0d beats=%0d left=%0d required done beats=%0d left=0", cyc, beats, exp_q.size(), NBEATS);
    end
  endtask

  task automatic test_ignored_triggers();
    int cyc;
    load_regs(5);
    beats = 0;
    push_dump();
    pulse_start();
    repeat (20) @(posedge clk1);
    #1 start = 1'b1;
    @(posedge clk1); #1 start = 1'b0;
    repeat (10) @(posedge clk1);
    #1 halted = 1'b1;
    wait_done(cyc);
    total++;
    if (cyc == 0) begin bad++; $display("FAIL ignored_done: timeout required done"); end
    repeat (20) @(negedge clk1);
    total++;
    if (busy !== 1'b0 || beats != NBEATS || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ignored_triggers: busy=%0b beats=%0d left=%0d required 0 %0d 0", busy, beats, exp_q.size(), NBEATS);
    end
    halted = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_regs(7);
    beats = 0;
    push_dump();
    pulse_start();
    for (int i = 0; i < 500 && beats < 10; i++) @(negedge clk1);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rf_rd_en, rf_rd_addr, out_valid, out_idx, out_data, out_last, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_mid_vals: valid=%0b idx=%0d data=%h busy=%0b required all 0", out_valid, out_idx, out_data, busy);
    end
    exp_q.delete();
    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    beats = 0;
    load_regs(11);
    push_dump();
    pulse_start();
    wait_done(cyc);
    total++;
    if (cyc == 0 || beats != NBEATS || exp_q.size() != 0) begin
      bad++;
      $display("FAIL restart_dump: cyc=%0d beats=%0d left=%0d required done %0d 0", cyc, beats, exp_q.size(), NBEATS);
    end
  endtask

  task automatic test_single_trigger();
    int cyc;
    // Halted already high when reset releases
    load_regs(2);
    rst_n = 1'b0;
    halted = 1'b1;
    repeat (2) @(posedge clk1);
    beats = 0;
    exp_q.delete();
    push_dump();
    #1 rst_n = 1'b1;
    wait_done(cyc);
    repeat (20) @(negedge clk1);
    total++;
    if (cyc == 0 || busy !== 1'b0 || beats != NBEATS || exp_q.size() != 0) begin
      bad++;
      $display("FAIL halted_at_reset: cyc=%0d busy=%0b beats=%0d required one dump of %0d", cyc, busy, beats, NBEATS);
    end
    halted = 1'b0;
    repeat (3) @(posedge clk1);
    // start and halted edge together
    load_regs(9);
    beats = 0;
    push_dump();
    #1 start = 1'b1; halted = 1'b1;
    @(posedge clk1); #1 start = 1'b0;
    wait_done(cyc);
    repeat (20) @(negedge clk1);
    total++;
    if (cyc == 0 || busy !== 1'b0 || beats != NBEATS || exp_q.size() != 0) begin
      bad++;
      $display("FAIL same_cycle_trig: cyc=%0d busy=%0b beats=%0d required one dump of %0d", cyc, busy, beats, NBEATS);
    end
    halted = 1'b0;
  endtask

  initial begin
    load_regs(0);
    test_reset();
    test_halted_dump();
    test_backpressure();
    test_ignored_triggers();
    test_reset_mid();
    test_single_trigger();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
